// File: rtl/uart_mirror.sv
// uart_mirror: 8N1 line echo. Bytes are collected until LF, then the line is replayed followed by CR LF.
// Build option: define UART_MIRROR_REVERSE_EN to replay the stored bytes last-first.
module uart_mirror #(
   parameter int CLKS_PER_BIT = 1250,
   parameter int DEPTH        = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic uart_rx,
   output logic uart_tx,
   output logic j3_10,
   output logic j3_9,
   output logic j3_8,
   output logic gled5,
   output logic rled1,
   output logic rled2,
   output logic rled3,
   output logic rled4
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = AW + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [NW-1:0] FULL      = NW'(DEPTH);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
   typedef enum logic [1:0] {COLLECT, SEND_DATA, SEND_CR, SEND_LF} line_state_t;

   // receive side
   logic          r_rx_meta;
   logic          r_rx_sync;
   logic          r_rx_prev;
   logic          w_rx_fall;
   rx_state_t     r_rx_state;
   rx_state_t     w_rx_state_nxt;
   logic          w_rx_tick;
   logic [CW-1:0] r_rx_clk;
   logic [2:0]    r_rx_bit;
   logic [7:0]    r_rx_shift;
   logic [7:0]    r_rx_byte;
   logic          r_rx_valid;
   logic          r_rx_ferr;

   // transmit side
   tx_state_t     r_tx_state;
   tx_state_t     w_tx_state_nxt;
   logic [8:0]    r_tx_frame;
   logic [3:0]    r_tx_bitn;
   logic [CW-1:0] r_tx_clk;
   logic          r_tx_out;
   logic          w_tx_last;
   logic          w_tx_ready;
   logic          w_tx_load;
   logic [7:0]    w_tx_byte;

   // line buffer and control
   line_state_t   r_line_state;
   line_state_t   w_line_nxt;
   logic [7:0]    r_mem [DEPTH];
   logic [NW-1:0] r_count;
   logic [NW-1:0] r_idx;
   logic [AW-1:0] w_rd_addr;
   logic [7:0]    w_rd_byte;
   logic          w_append;
   logic          w_idx_inc;
   logic          w_line_done;
   logic          r_gled;

   // History flops reset low so that a line held low through reset is never taken as a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b0;
         r_rx_sync <= 1'b0;
         r_rx_prev <= 1'b0;
      end else begin
         r_rx_meta <= uart_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_rx_fall = r_rx_prev & ~r_rx_sync;

   // Receiver next-state: half-bit start check, then one sample per bit period.
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_tick      = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (w_rx_fall) begin
               w_rx_state_nxt = RX_START;
            end else begin
               w_rx_state_nxt = RX_IDLE;
            end
         end
         RX_START: begin
            if (r_rx_clk == HALF_LAST) begin
               w_rx_tick      = 1'b1;
               w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               w_rx_state_nxt = RX_START;
            end
         end
         RX_DATA: begin
            if (r_rx_clk == BIT_LAST) begin
               w_rx_tick      = 1'b1;
               w_rx_state_nxt = (r_rx_bit == 3'd7) ? RX_STOP : RX_DATA;
            end else begin
               w_rx_state_nxt = RX_DATA;
            end
         end
         RX_STOP: begin
            if (r_rx_clk == BIT_LAST) begin
               w_rx_tick      = 1'b1;
               w_rx_state_nxt = RX_IDLE;
            end else begin
               w_rx_state_nxt = RX_STOP;
            end
         end
         default: begin
            w_rx_state_nxt = RX_IDLE;
         end
      endcase
   end

   // Receiver state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
      end else begin
         r_rx_state <= w_rx_state_nxt;
      end
   end

   // Receiver datapath: bit timer, shift register, accept / framing-error strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_clk   <= '0;
         r_rx_bit   <= 3'd0;
         r_rx_shift <= 8'h00;
         r_rx_byte  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
         if ((r_rx_state == RX_IDLE) || w_rx_tick) begin
            r_rx_clk <= '0;
         end else begin
            r_rx_clk <= r_rx_clk + CW'(1);
         end
         if (r_rx_state == RX_START) begin
            r_rx_bit <= 3'd0;
         end else if ((r_rx_state == RX_DATA) && w_rx_tick) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end else if ((r_rx_state == RX_STOP) && w_rx_tick) begin
            if (r_rx_sync) begin
               r_rx_valid <= 1'b1;
               r_rx_byte  <= r_rx_shift;
            end else begin
               r_rx_ferr <= 1'b1;
            end
         end
      end
   end

   // Last cycle of a stop bit; a new load here keeps bytes back-to-back.
   assign w_tx_last  = (r_tx_state == TX_BUSY) && (r_tx_clk == BIT_LAST) && (r_tx_bitn == 4'd9);
   assign w_tx_ready = (r_tx_state == TX_IDLE) || w_tx_last;

   // Transmitter next-state.
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      case (r_tx_state)
         TX_IDLE: begin
            if (w_tx_load) begin
               w_tx_state_nxt = TX_BUSY;
            end else begin
               w_tx_state_nxt = TX_IDLE;
            end
         end
         TX_BUSY: begin
            if (w_tx_last && !w_tx_load) begin
               w_tx_state_nxt = TX_IDLE;
            end else begin
               w_tx_state_nxt = TX_BUSY;
            end
         end
         default: begin
            w_tx_state_nxt = TX_IDLE;
         end
      endcase
   end

   // Transmitter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
      end else begin
         r_tx_state <= w_tx_state_nxt;
      end
   end

   // Transmitter datapath: frame holds data plus stop bit; the line bit is registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_frame <= 9'h1FF;
         r_tx_bitn  <= 4'd0;
         r_tx_clk   <= '0;
         r_tx_out   <= 1'b1;
      end else if (w_tx_load) begin
         r_tx_frame <= {1'b1, w_tx_byte};
         r_tx_bitn  <= 4'd0;
         r_tx_clk   <= '0;
         r_tx_out   <= 1'b0;
      end else if (r_tx_state == TX_BUSY) begin
         if (r_tx_clk == BIT_LAST) begin
            r_tx_clk <= '0;
            if (r_tx_bitn == 4'd9) begin
               r_tx_out <= 1'b1;
            end else begin
               r_tx_bitn  <= r_tx_bitn + 4'd1;
               r_tx_out   <= r_tx_frame[0];
               r_tx_frame <= {1'b1, r_tx_frame[8:1]};
            end
         end else begin
            r_tx_clk <= r_tx_clk + CW'(1);
         end
      end else begin
         r_tx_clk <= '0;
         r_tx_out <= 1'b1;
      end
   end

`ifdef UART_MIRROR_REVERSE_EN
   assign w_rd_addr = AW'(r_count - r_idx - NW'(1));
`else
   assign w_rd_addr = AW'(r_idx);
`endif
   assign w_rd_byte = r_mem[w_rd_addr];

   // Line controller next-state and transmit requests.
   always_comb begin
      w_line_nxt  = r_line_state;
      w_tx_load   = 1'b0;
      w_tx_byte   = 8'h00;
      w_append    = 1'b0;
      w_idx_inc   = 1'b0;
      w_line_done = 1'b0;
      case (r_line_state)
         COLLECT: begin
            if (r_rx_valid) begin
               if (r_rx_byte == 8'h0A) begin
                  w_line_nxt = SEND_DATA;
               end else if ((r_rx_byte != 8'h0D) && (r_count != FULL)) begin
                  w_append = 1'b1;
               end else begin
                  w_append = 1'b0;
               end
            end else begin
               w_line_nxt = COLLECT;
            end
         end
         SEND_DATA: begin
            if (w_tx_ready) begin
               w_tx_load = 1'b1;
               if (r_idx < r_count) begin
                  w_tx_byte = w_rd_byte;
                  w_idx_inc = 1'b1;
               end else begin
                  w_tx_byte  = 8'h0D;
                  w_line_nxt = SEND_CR;
               end
            end else begin
               w_line_nxt = SEND_DATA;
            end
         end
         SEND_CR: begin
            if (w_tx_ready) begin
               w_tx_load  = 1'b1;
               w_tx_byte  = 8'h0A;
               w_line_nxt = SEND_LF;
            end else begin
               w_line_nxt = SEND_CR;
            end
         end
         SEND_LF: begin
            if (w_tx_ready) begin
               w_line_done = 1'b1;
               w_line_nxt  = COLLECT;
            end else begin
               w_line_nxt = SEND_LF;
            end
         end
         default: begin
            w_line_nxt = COLLECT;
         end
      endcase
   end

   // Line controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_line_state <= COLLECT;
      end else begin
         r_line_state <= w_line_nxt;
      end
   end

   // Buffer storage; reads are gated by r_count so contents need no reset.
   always_ff @(posedge clk) begin
      if (w_append) begin
         r_mem[AW'(r_count)] <= r_rx_byte;
      end
   end

   // Fill count, replay index and busy indicator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_idx   <= '0;
         r_gled  <= 1'b0;
      end else begin
         if (w_line_done) begin
            r_count <= '0;
            r_idx   <= '0;
         end else begin
            if (w_append) begin
               r_count <= r_count + NW'(1);
            end
            if (w_idx_inc) begin
               r_idx <= r_idx + NW'(1);
            end
         end
         if (w_tx_load) begin
            r_gled <= 1'b1;
         end else if (w_line_done) begin
            r_gled <= 1'b0;
         end
      end
   end

   assign uart_tx = r_tx_out;
   assign j3_9    = r_tx_out;
   assign j3_10   = r_rx_sync;
   assign j3_8    = r_rx_ferr;
   assign gled5   = r_gled;
   assign rled1   = r_rx_byte[0];
   assign rled2   = r_rx_byte[1];
   assign rled3   = r_rx_byte[2];
   assign rled4   = r_rx_byte[3];

endmodule

// File: tb/tb_uart_mirror.sv
// Directed bench for uart_mirror: serial driver on uart_rx, serial decoder on uart_tx.
`timescale 1ns/1ps
module tb_uart_mirror;

   localparam int C = 32;
   localparam int H = C / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_rx = 1'b1;
   logic uart_tx, j3_10, j3_9, j3_8, gled5, rled1, rled2, rled3, rled4;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gled_cnt = 0;
   int ferr_cnt = 0;
   int tx_start_cyc = 0;

   logic [7:0] mon_q[$];
   logic       mon_stop[$];
   int         mon_t[$];
   logic       mon_prev = 1'b1;
   logic [7:0] mon_b;

   uart_mirror #(.CLKS_PER_BIT(C), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .j3_10(j3_10), .j3_9(j3_9), .j3_8(j3_8), .gled5(gled5),
      .rled1(rled1), .rled2(rled2), .rled3(rled3), .rled4(rled4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (gled5 === 1'b1) gled_cnt <= gled_cnt + 1;
      if (j3_8 === 1'b1) ferr_cnt <= ferr_cnt + 1;
   end

   // serial decoder on uart_tx, sampling mid-bit
   initial begin
      forever begin
         @(negedge clk);
         if (mon_prev === 1'b1 && uart_tx === 1'b0) begin
            mon_t.push_back(cyc);
            repeat (H) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (C) @(negedge clk);
               mon_b[b] = uart_tx;
            end
            repeat (C) @(negedge clk);
            mon_q.push_back(mon_b);
            mon_stop.push_back(uart_tx);
         end
         mon_prev = uart_tx;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic stop_v);
      @(negedge clk);
      tx_start_cyc = cyc;
      uart_rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (C) @(negedge clk);
      end
      uart_rx = stop_v;
      repeat (C) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic wait_tx(input int n, input int budget);
      for (int i = 0; i < budget && mon_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 * C && gled5 !== 1'b0; i++) @(negedge clk);
      repeat (2 * C) @(negedge clk);
   endtask

   task automatic clear_mon();
      mon_q.delete();
      mon_stop.delete();
      mon_t.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
      checks++; if (j3_9 !== 1'b1) begin errors++; $display("FAIL reset_j3_9 got %b want 1", j3_9); end
      checks++; if (gled5 !== 1'b0) begin errors++; $display("FAIL reset_gled5 got %b want 0", gled5); end
      checks++; if ({rled4, rled3, rled2, rled1} !== 4'h0) begin errors++; $display("FAIL reset_rled got %h want 0", {rled4, rled3, rled2, rled1}); end
      checks++; if (j3_8 !== 1'b0) begin errors++; $display("FAIL reset_j3_8 got %b want 0", j3_8); end
      rst = 1'b0;
      repeat (4 * C) @(negedge clk);
      checks++; if (mon_q.size() !== 0) begin errors++; $display("FAIL reset_quiet got %0d bytes want 0", mon_q.size()); end
      checks++; if (j3_10 !== 1'b1) begin errors++; $display("FAIL sync_rx got %b want 1", j3_10); end
   endtask

   task automatic test_line();
      logic [7:0] exp [6];
      int g0, lat;
`ifdef UART_MIRROR_REVERSE_EN
      exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h0D, 8'h0A};
`else
      exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h0A};
`endif
      clear_mon();
      g0 = gled_cnt;
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h04, 1'b1);
      send_byte(8'h0D, 1'b1);
      send_byte(8'h0A, 1'b1);
      wait_tx(6, 100 * C);
      checks++; if (mon_q.size() !== 6) begin errors++; $display("FAIL line_count got %0d want 6", mon_q.size()); end
      if (mon_q.size() >= 6) begin
         for (int i = 0; i < 6; i++) begin
            checks++; if (mon_q[i] !== exp[i]) begin errors++; $display("FAIL line_byte%0d got %h want %h", i, mon_q[i], exp[i]); end
            checks++; if (mon_stop[i] !== 1'b1) begin errors++; $display("FAIL line_stop%0d got %b want 1", i, mon_stop[i]); end
         end
         for (int i = 1; i < 6; i++) begin
            checks++; if (mon_t[i] - mon_t[i-1] !== 10 * C) begin errors++; $display("FAIL line_gap%0d got %0d want %0d", i, mon_t[i] - mon_t[i-1], 10 * C); end
         end
         lat = mon_t[0] - tx_start_cyc;
         checks++; if (lat < 9 * C + H || lat > 9 * C + H + 8) begin errors++; $display("FAIL line_latency got %0d want %0d..%0d", lat, 9 * C + H, 9 * C + H + 8); end
      end
      wait_idle();
      checks++; if ({rled4, rled3, rled2, rled1} !== 4'hA) begin errors++; $display("FAIL line_rled got %h want a", {rled4, rled3, rled2, rled1}); end
      checks++; if (gled_cnt - g0 !== 60 * C) begin errors++; $display("FAIL line_gled got %0d want %0d", gled_cnt - g0, 60 * C); end
   endtask

   task automatic test_empty_line();
      int g0;
      clear_mon();
      g0 = gled_cnt;
      send_byte(8'h0A, 1'b1);
      wait_tx(2, 40 * C);
      checks++; if (mon_q.size() !== 2) begin errors++; $display("FAIL empty_count got %0d want 2", mon_q.size()); end
      if (mon_q.size() >= 2) begin
         checks++; if (mon_q[0] !== 8'h0D) begin errors++; $display("FAIL empty_cr got %h want 0d", mon_q[0]); end
         checks++; if (mon_q[1] !== 8'h0A) begin errors++; $display("FAIL empty_lf got %h want 0a", mon_q[1]); end
      end
      wait_idle();
      checks++; if (gled_cnt - g0 !== 20 * C) begin errors++; $display("FAIL empty_gled got %0d want %0d", gled_cnt - g0, 20 * C); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp [18];
      for (int i = 0; i < 16; i++) begin
`ifdef UART_MIRROR_REVERSE_EN
         exp[i] = 8'h50 - 8'(i);
`else
         exp[i] = 8'h41 + 8'(i);
`endif
      end
      exp[16] = 8'h0D;
      exp[17] = 8'h0A;
      clear_mon();
      for (int i = 0; i < 17; i++) send_byte(8'h41 + 8'(i), 1'b1);
      send_byte(8'h0A, 1'b1);
      wait_tx(18, 250 * C);
      checks++; if (mon_q.size() !== 18) begin errors++; $display("FAIL ovf_count got %0d want 18", mon_q.size()); end
      if (mon_q.size() >= 18) begin
         for (int i = 0; i < 18; i++) begin
            checks++; if (mon_q[i] !== exp[i]) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, mon_q[i], exp[i]); end
         end
      end
      wait_idle();
   endtask

   task automatic test_frame_error();
      int f0;
      clear_mon();
      f0 = ferr_cnt;
      send_byte(8'h55, 1'b0);
      repeat (2 * C) @(negedge clk);
      checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got %0d cycles want 1", ferr_cnt - f0); end
      checks++; if ({rled4, rled3, rled2, rled1} !== 4'hA) begin errors++; $display("FAIL ferr_rled got %h want a", {rled4, rled3, rled2, rled1}); end
      send_byte(8'h0A, 1'b1);
      wait_tx(2, 40 * C);
      repeat (4 * C) @(negedge clk);
      checks++; if (mon_q.size() !== 2) begin errors++; $display("FAIL ferr_count got %0d want 2", mon_q.size()); end
      if (mon_q.size() >= 2) begin
         checks++; if (mon_q[0] !== 8'h0D || mon_q[1] !== 8'h0A) begin errors++; $display("FAIL ferr_line got %h %h want 0d 0a", mon_q[0], mon_q[1]); end
      end
      wait_idle();
   endtask

   task automatic test_glitch();
      int f0;
      clear_mon();
      f0 = ferr_cnt;
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (6) @(negedge clk);
      uart_rx = 1'b1;
      repeat (12 * C) @(negedge clk);
      checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - f0); end
      checks++; if ({rled4, rled3, rled2, rled1} !== 4'hA) begin errors++; $display("FAIL glitch_rled got %h want a", {rled4, rled3, rled2, rled1}); end
      send_byte(8'h0A, 1'b1);
      wait_tx(2, 40 * C);
      repeat (4 * C) @(negedge clk);
      checks++; if (mon_q.size() !== 2) begin errors++; $display("FAIL glitch_count got %0d want 2", mon_q.size()); end
      wait_idle();
   endtask

   task automatic test_reset_mid_tx();
      int idx;
`ifdef UART_MIRROR_REVERSE_EN
      idx = 1;
`else
      idx = 2;
`endif
      clear_mon();
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h0A, 1'b1);
      for (int i = 0; i < 40 * C && mon_t.size() < idx; i++) @(negedge clk);
      checks++; if (mon_t.size() < idx) begin errors++; $display("FAIL rstmid_reach got %0d starts want %0d", mon_t.size(), idx); end
      repeat (3 * C + H) @(negedge clk);
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre got %b want 0", uart_tx); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", uart_tx); end
      checks++; if (gled5 !== 1'b0) begin errors++; $display("FAIL rstmid_gled got %b want 0", gled5); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (12 * C) @(negedge clk);
      clear_mon();
      send_byte(8'h0A, 1'b1);
      wait_tx(2, 40 * C);
      repeat (4 * C) @(negedge clk);
      checks++; if (mon_q.size() !== 2) begin errors++; $display("FAIL rstmid_count got %0d want 2", mon_q.size()); end
      if (mon_q.size() >= 2) begin
         checks++; if (mon_q[0] !== 8'h0D || mon_q[1] !== 8'h0A) begin errors++; $display("FAIL rstmid_line got %h %h want 0d 0a", mon_q[0], mon_q[1]); end
      end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_line();
      test_empty_line();
      test_overflow();
      test_frame_error();
      test_glitch();
      test_reset_mid_tx();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
